xspi_slave_8s: RTL and testbench

XSPI_SLAVE_8S -- requirements
Module: xspi_slave_8s

---
 rtl/xspi_slave_8s.sv | 204 ++++++++++++++++++++
 tb/tb_xspi_slave_8s.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xspi_slave_8s.sv
// Octal (x8) SPI-style slave with a 16 x 64-bit word memory.
//
// A transaction is framed by cs_n_i low. It starts with one opcode byte, then 4 address bytes
// (MSB first). A write opcode is followed by 8 data bytes (MSB first), which are committed to
// memory on the 8th byte. A read opcode is followed by DUMMY_CYCLES turnaround cycles and then
// 8 data bytes that the slave drives (MSB first). The word index is addr[6:3]; all other address
// bits alias.
//
// Ports:
//   clk_i      - single clock; every bus signal is sampled and driven on its rising edge
//   rst_i      - synchronous, active-high reset
//   cs_n_i     - chip select, active low
//   io_in_i    - 8-bit bus from the master
//   io_out_o   - 8-bit bus to the master (registered)
//   io_oe_o    - output enable for io_out_o (registered)
//   ready_o    - single pulse in the first cycle after reset release
//   wr_done_o  - pulse: a 64-bit word has been committed to memory
//   rd_done_o  - pulse: the 8th read byte has been driven
//   busy_o     - high whenever the controller is not idle
module xspi_slave_8s #(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  CMD_WRITE    = 8'h02,
    parameter logic [7:0]  CMD_READ     = 8'h0B
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_n_i,
    input  logic [7:0] io_in_i,
    output logic [7:0] io_out_o,
    output logic       io_oe_o,
    output logic       ready_o,
    output logic       wr_done_o,
    output logic       rd_done_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {StIdle, StAddr, StDummy, StRdata, StWdata, StWait} state_e;

    localparam logic [3:0] DummyLast = 4'(DUMMY_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] sh_q, sh_d;
    logic        is_rd_q, is_rd_d;
    // Set by any cycle with cs_n high; an opcode is only accepted while set. Cleared by reset so
    // that a cs_n held low across reset release is not taken as an opcode.
    logic        armed_q, armed_d;
    logic        init_q, ready_q;
    logic [7:0]  io_out_q, io_out_d;
    logic        io_oe_q, io_oe_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_done_q, rd_done_d;
    logic [63:0] mem_q [16];
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] rd_word;
    logic        abort;

    assign abort   = (state_q != StIdle) && cs_n_i;
    assign rd_word = mem_q[addr_q[6:3]];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!cs_n_i && armed_q) begin
                        state_d = (io_in_i == CMD_WRITE || io_in_i == CMD_READ) ? StAddr : StWait;
                    end
                end
                StAddr:  if (cnt_q == 4'd3) state_d = is_rd_q ? StDummy : StWdata;
                StDummy: if (cnt_q == DummyLast) state_d = StRdata;
                StRdata: if (cnt_q == 4'd7) state_d = StWait;
                StWdata: if (cnt_q == 4'd7) state_d = StWait;
                StWait:  state_d = StWait;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output and datapath next-state logic
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        sh_d      = sh_q;
        is_rd_d   = is_rd_q;
        armed_d   = cs_n_i ? 1'b1 : armed_q;
        io_out_d  = io_out_q;
        io_oe_d   = 1'b0;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = {sh_q[55:0], io_in_i};
        if (abort) begin
            io_out_d = 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!cs_n_i && armed_q) begin
                        is_rd_d = (io_in_i == CMD_READ);
                        cnt_d   = 4'd0;
                        armed_d = 1'b0;
                    end
                end
                StAddr: begin
                    addr_d = {addr_q[23:0], io_in_i};
                    cnt_d  = (cnt_q == 4'd3) ? 4'd0 : cnt_q + 4'd1;
                end
                StDummy: begin
                    if (cnt_q == DummyLast) begin
                        // Fetch the word and present its first byte so it is valid for the
                        // whole first data cycle.
                        io_oe_d  = 1'b1;
                        io_out_d = rd_word[63:56];
                        sh_d     = {rd_word[55:0], 8'h00};
                        cnt_d    = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StRdata: begin
                    if (cnt_q == 4'd7) begin
                        rd_done_d = 1'b1;
                        io_out_d  = 8'h00;
                        cnt_d     = 4'd0;
                    end else begin
                        io_oe_d  = 1'b1;
                        io_out_d = sh_q[63:56];
                        sh_d     = {sh_q[55:0], 8'h00};
                        cnt_d    = cnt_q + 4'd1;
                    end
                end
                StWdata: begin
                    sh_d = {sh_q[55:0], io_in_i};
                    if (cnt_q == 4'd7) begin
                        mem_we    = 1'b1;
                        wr_done_d = 1'b1;
                        cnt_d     = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StWait: io_out_d = 8'h00;
                default: io_out_d = 8'h00;
            endcase
        end
    end

    // Datapath and memory registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            sh_q      <= '0;
            is_rd_q   <= 1'b0;
            armed_q   <= 1'b0;
            init_q    <= 1'b0;
            ready_q   <= 1'b0;
            io_out_q  <= '0;
            io_oe_q   <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sh_q      <= sh_d;
            is_rd_q   <= is_rd_d;
            armed_q   <= armed_d;
            init_q    <= 1'b1;
            ready_q   <= ~init_q;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            if (mem_we) begin
                mem_q[addr_q[6:3]] <= mem_wdata;
            end
        end
    end

    assign io_out_o  = io_out_q;
    assign io_oe_o   = io_oe_q;
    assign ready_o   = ready_q;
    assign wr_done_o = wr_done_q;
    assign rd_done_o = rd_done_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_xspi_slave_8s.sv
// Self-checking bench for xspi_slave_8s: directed scenarios plus randomized read/write traffic,
// checked against a plain word-array model of the slave memory.
module tb_xspi_slave_8s;

    localparam int unsigned Dummy = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic       io_oe;
    logic       ready;
    logic       wr_done;
    logic       rd_done;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [63:0] model_mem [16];

    xspi_slave_8s #(
        .DUMMY_CYCLES(Dummy),
        .CMD_WRITE   (8'h02),
        .CMD_READ    (8'h0B)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cs_n_i   (cs_n),
        .io_in_i  (io_in),
        .io_out_o (io_out),
        .io_oe_o  (io_oe),
        .ready_o  (ready),
        .wr_done_o(wr_done),
        .rd_done_o(rd_done),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable for the new cycle and inputs may be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_mem[i] = 64'h0;
    endtask

    // Flags vector = {busy, io_oe, wr_done, rd_done, ready}
    task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input string name);
        cs_n  = 1'b0;
        io_in = 8'h02;
        tick();
        for (int i = 0; i < 4; i++) begin
            io_in = addr[31-8*i -: 8];
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b10000) begin
                errors++;
                $display("FAIL %s addr phase flags got %b want 10000", name,
                         {busy, io_oe, wr_done, rd_done, ready});
            end
        end
        for (int i = 0; i < 8; i++) begin
            io_in = data[63-8*i -: 8];
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== ((i == 7) ? 5'b10100 : 5'b10000)) begin
                errors++;
                $display("FAIL %s data byte %0d flags got %b want %b", name, i,
                         {busy, io_oe, wr_done, rd_done, ready},
                         (i == 7) ? 5'b10100 : 5'b10000);
            end
        end
        model_mem[addr[6:3]] = data;
        cs_n  = 1'b1;
        io_in = 8'($urandom);
        tick();
        checks++;
        if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00000) begin
            errors++;
            $display("FAIL %s end flags got %b want 00000", name,
                     {busy, io_oe, wr_done, rd_done, ready});
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input string name);
        logic [63:0] exp;
        exp   = model_mem[addr[6:3]];
        cs_n  = 1'b0;
        io_in = 8'h0B;
        tick();
        for (int i = 0; i < 4; i++) begin
            io_in = addr[31-8*i -: 8];
            tick();
        end
        // First dummy cycle, then the remaining ones: bus must stay released.
        for (int d = 0; d < Dummy; d++) begin
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b10000) begin
                errors++;
                $display("FAIL %s dummy %0d flags got %b want 10000", name, d,
                         {busy, io_oe, wr_done, rd_done, ready});
            end
            io_in = 8'($urandom);
            if (d != Dummy - 1) tick();
        end
        for (int b = 0; b < 8; b++) begin
            tick();
            checks++;
            if ({io_oe, rd_done, io_out} !== {2'b10, exp[63-8*b -: 8]}) begin
                errors++;
                $display("FAIL %s byte %0d oe/done/data got %b/%b/%h want 1/0/%h", name, b,
                         io_oe, rd_done, io_out, exp[63-8*b -: 8]);
            end
        end
        tick();
        checks++;
        if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b10010) begin
            errors++;
            $display("FAIL %s rd_done flags got %b want 10010", name,
                     {busy, io_oe, wr_done, rd_done, ready});
        end
        cs_n = 1'b1;
        tick();
        checks++;
        if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00000) begin
            errors++;
            $display("FAIL %s end flags got %b want 00000", name,
                     {busy, io_oe, wr_done, rd_done, ready});
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        cs_n  = 1'b1;
        io_in = 8'h00;
        clear_model();
        repeat (3) tick();
        checks++;
        if ({io_out, io_oe, ready, wr_done, rd_done, busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset outputs got %h/%b%b%b%b%b want all zero", io_out, io_oe, ready,
                     wr_done, rd_done, busy);
        end
        // Hold cs_n low across release with a valid opcode: it must be ignored.
        rst   = 1'b0;
        cs_n  = 1'b0;
        io_in = 8'h0B;
        tick();
        checks++;
        if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00001) begin
            errors++;
            $display("FAIL ready_pulse flags got %b want 00001",
                     {busy, io_oe, wr_done, rd_done, ready});
        end
        io_in = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00000) begin
                errors++;
                $display("FAIL post_reset_ignore cycle %0d flags got %b want 00000", i,
                         {busy, io_oe, wr_done, rd_done, ready});
            end
        end
        cs_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        do_write(32'h0000_0008, 64'h1122334455667788, "wr_word1");
        do_read(32'h0000_0008, "rd_word1");
        do_read(32'h0000_0088, "rd_alias_word1");
        do_read(32'h0000_0018, "rd_word3_unwritten");
    endtask

    task automatic abort_write_word2(input bit use_rst);
        cs_n  = 1'b0;
        io_in = 8'h02;
        tick();
        for (int i = 0; i < 4; i++) begin
            io_in = (i == 3) ? 8'h10 : 8'h00;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            io_in = 8'hA0 + 8'(i);
            tick();
        end
        if (use_rst) begin
            rst = 1'b1;
            repeat (2) tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready, io_out} !== 13'h0) begin
                errors++;
                $display("FAIL rst_abort in reset got %b/%h want 00000/00",
                         {busy, io_oe, wr_done, rd_done, ready}, io_out);
            end
            clear_model();
            rst  = 1'b0;
            cs_n = 1'b1;
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00001) begin
                errors++;
                $display("FAIL rst_abort ready flags got %b want 00001",
                         {busy, io_oe, wr_done, rd_done, ready});
            end
        end else begin
            cs_n = 1'b1;
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00000) begin
                errors++;
                $display("FAIL cs_abort flags got %b want 00000",
                         {busy, io_oe, wr_done, rd_done, ready});
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b00000) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d flags got %b want 00000", i,
                         {busy, io_oe, wr_done, rd_done, ready});
            end
        end
    endtask

    task automatic test_abort();
        abort_write_word2(1'b0);
        do_read(32'h0000_0010, "rd_word2_after_cs_abort");
        // Partial read: release cs_n mid-data; no rd_done may follow.
        cs_n  = 1'b0;
        io_in = 8'h0B;
        tick();
        for (int i = 0; i < 4; i++) begin
            io_in = (i == 3) ? 8'h08 : 8'h00;
            tick();
        end
        repeat (Dummy + 3) tick();
        cs_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done} !== 4'b0000) begin
                errors++;
                $display("FAIL partial_read cycle %0d flags got %b want 0000", i,
                         {busy, io_oe, wr_done, rd_done});
            end
        end
        abort_write_word2(1'b1);
        do_read(32'h0000_0010, "rd_word2_after_rst_abort");
        do_read(32'h0000_0008, "rd_word1_after_rst");
    endtask

    task automatic test_bad_opcode();
        do_write(32'h0000_0028, 64'hDEAD_BEEF_0123_4567, "wr_word5");
        cs_n  = 1'b0;
        io_in = 8'hFF;
        tick();
        for (int i = 0; i < 12; i++) begin
            io_in = (i < 2) ? 8'h02 : 8'($urandom);
            tick();
            checks++;
            if ({busy, io_oe, wr_done, rd_done, ready} !== 5'b10000) begin
                errors++;
                $display("FAIL bad_opcode cycle %0d flags got %b want 10000", i,
                         {busy, io_oe, wr_done, rd_done, ready});
            end
        end
        cs_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_opcode release busy got %b want 0", busy);
        end
        do_read(32'h0000_0028, "rd_word5_after_bad_op");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int t = 0; t < 24; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, {$urandom, $urandom}, "rand_wr");
            end else begin
                do_read(a, "rand_rd");
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int w = 0; w < 16; w++) begin
            do_read(32'($urandom) & 32'hFFFF_FF87 | 32'(w << 3), "sweep_rd");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_bad_opcode();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
